// File: rtl/ip_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : ip_tx_arb
// Brief    : Round-robin frame arbiter feeding the IP transmit header/payload.
// Revision : 1.0 - initial release
// ============================================================================
module ip_tx_arb #(
    parameter int S_COUNT    = 2,
    parameter int CL_S_COUNT = $clog2(S_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [S_COUNT-1:0]      s_ip_hdr_valid,
    output logic [S_COUNT-1:0]      s_ip_hdr_ready,
    input  logic [6*S_COUNT-1:0]    s_ip_dscp,
    input  logic [2*S_COUNT-1:0]    s_ip_ecn,
    input  logic [16*S_COUNT-1:0]   s_ip_length,
    input  logic [8*S_COUNT-1:0]    s_ip_ttl,
    input  logic [8*S_COUNT-1:0]    s_ip_protocol,
    input  logic [32*S_COUNT-1:0]   s_ip_source_ip,
    input  logic [32*S_COUNT-1:0]   s_ip_dest_ip,
    input  logic [8*S_COUNT-1:0]    s_ip_payload_axis_tdata,
    input  logic [S_COUNT-1:0]      s_ip_payload_axis_tvalid,
    output logic [S_COUNT-1:0]      s_ip_payload_axis_tready,
    input  logic [S_COUNT-1:0]      s_ip_payload_axis_tlast,
    input  logic [S_COUNT-1:0]      s_ip_payload_axis_tuser,

    output logic                    m_ip_hdr_valid,
    input  logic                    m_ip_hdr_ready,
    output logic [5:0]              m_ip_dscp,
    output logic [1:0]              m_ip_ecn,
    output logic [15:0]             m_ip_length,
    output logic [7:0]              m_ip_ttl,
    output logic [7:0]              m_ip_protocol,
    output logic [31:0]             m_ip_source_ip,
    output logic [31:0]             m_ip_dest_ip,
    output logic [7:0]              m_ip_payload_axis_tdata,
    output logic                    m_ip_payload_axis_tvalid,
    input  logic                    m_ip_payload_axis_tready,
    output logic                    m_ip_payload_axis_tlast,
    output logic                    m_ip_payload_axis_tuser,

    output logic                    grant_valid,
    output logic [CL_S_COUNT-1:0]   grant_index
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CL_S_COUNT-1:0]   r_rr_ptr;
    logic [CL_S_COUNT-1:0]   r_grant_index;
    logic                    r_grant_valid;
    logic                    r_hdr_valid;
    logic [5:0]              r_dscp;
    logic [1:0]              r_ecn;
    logic [15:0]             r_length;
    logic [7:0]              r_ttl;
    logic [7:0]              r_protocol;
    logic [31:0]             r_source_ip;
    logic [31:0]             r_dest_ip;

    logic                    w_found;
    logic [CL_S_COUNT-1:0]   w_winner;
    logic [CL_S_COUNT-1:0]   w_ptr_next;
    logic [5:0]              w_sel_dscp;
    logic [1:0]              w_sel_ecn;
    logic [15:0]             w_sel_length;
    logic [7:0]              w_sel_ttl;
    logic [7:0]              w_sel_protocol;
    logic [31:0]             w_sel_source_ip;
    logic [31:0]             w_sel_dest_ip;
    logic [7:0]              w_g_tdata;
    logic                    w_g_tvalid;
    logic                    w_g_tlast;
    logic                    w_g_tuser;
    logic                    w_pl_last;

    // Two descending passes: the lowest requester at or above the pointer wins,
    // otherwise the lowest requester below it (i.e. a wrapped upward scan).
    always_comb begin : p_select
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_ip_hdr_valid[i]) begin
                w_found  = 1'b1;
                w_winner = CL_S_COUNT'(i);
            end
        end
        for (int i = S_COUNT - 1; i >= 0; i--) begin
            if (s_ip_hdr_valid[i] && (CL_S_COUNT'(i) >= r_rr_ptr)) begin
                w_winner = CL_S_COUNT'(i);
            end
        end
    end

    assign w_ptr_next = (w_winner == CL_S_COUNT'(S_COUNT - 1)) ? '0 : w_winner + 1'b1;

    always_comb begin : p_hdr_mux
        w_sel_dscp      = '0;
        w_sel_ecn       = '0;
        w_sel_length    = '0;
        w_sel_ttl       = '0;
        w_sel_protocol  = '0;
        w_sel_source_ip = '0;
        w_sel_dest_ip   = '0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (w_winner == CL_S_COUNT'(i)) begin
                w_sel_dscp      = s_ip_dscp[i*6 +: 6];
                w_sel_ecn       = s_ip_ecn[i*2 +: 2];
                w_sel_length    = s_ip_length[i*16 +: 16];
                w_sel_ttl       = s_ip_ttl[i*8 +: 8];
                w_sel_protocol  = s_ip_protocol[i*8 +: 8];
                w_sel_source_ip = s_ip_source_ip[i*32 +: 32];
                w_sel_dest_ip   = s_ip_dest_ip[i*32 +: 32];
            end
        end
    end

    // Header accept is also gated by rst_n so every ready reads 0 while in reset.
    always_comb begin : p_hdr_ready
        s_ip_hdr_ready = '0;
        if (rst_n && (r_state == ST_IDLE) && w_found) begin
            s_ip_hdr_ready[w_winner] = 1'b1;
        end
    end

    always_comb begin : p_payload
        w_g_tdata  = '0;
        w_g_tvalid = 1'b0;
        w_g_tlast  = 1'b0;
        w_g_tuser  = 1'b0;
        for (int i = 0; i < S_COUNT; i++) begin
            if (r_grant_index == CL_S_COUNT'(i)) begin
                w_g_tdata  = s_ip_payload_axis_tdata[i*8 +: 8];
                w_g_tvalid = s_ip_payload_axis_tvalid[i];
                w_g_tlast  = s_ip_payload_axis_tlast[i];
                w_g_tuser  = s_ip_payload_axis_tuser[i];
            end
        end
        m_ip_payload_axis_tdata  = '0;
        m_ip_payload_axis_tvalid = 1'b0;
        m_ip_payload_axis_tlast  = 1'b0;
        m_ip_payload_axis_tuser  = 1'b0;
        s_ip_payload_axis_tready = '0;
        if (r_state == ST_PAYLOAD) begin
            m_ip_payload_axis_tdata  = w_g_tdata;
            m_ip_payload_axis_tvalid = w_g_tvalid;
            m_ip_payload_axis_tlast  = w_g_tlast;
            m_ip_payload_axis_tuser  = w_g_tuser;
            s_ip_payload_axis_tready[r_grant_index] = m_ip_payload_axis_tready;
        end
    end

    assign w_pl_last = m_ip_payload_axis_tvalid && m_ip_payload_axis_tready && m_ip_payload_axis_tlast;

    always_comb begin : p_next_state
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_found)        w_state_next = ST_HDR;
            ST_HDR:     if (m_ip_hdr_ready) w_state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (w_pl_last)      w_state_next = ST_IDLE;
            default:                        w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant_index <= '0;
            r_grant_valid <= 1'b0;
            r_hdr_valid   <= 1'b0;
            r_dscp        <= '0;
            r_ecn         <= '0;
            r_length      <= '0;
            r_ttl         <= '0;
            r_protocol    <= '0;
            r_source_ip   <= '0;
            r_dest_ip     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_dscp        <= w_sel_dscp;
                        r_ecn         <= w_sel_ecn;
                        r_length      <= w_sel_length;
                        r_ttl         <= w_sel_ttl;
                        r_protocol    <= w_sel_protocol;
                        r_source_ip   <= w_sel_source_ip;
                        r_dest_ip     <= w_sel_dest_ip;
                        r_hdr_valid   <= 1'b1;
                        r_grant_index <= w_winner;
                        r_grant_valid <= 1'b1;
                        r_rr_ptr      <= w_ptr_next;
                    end
                end
                ST_HDR: begin
                    if (m_ip_hdr_ready) begin
                        r_hdr_valid <= 1'b0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_pl_last) begin
                        r_grant_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_ip_hdr_valid = r_hdr_valid;
    assign m_ip_dscp      = r_dscp;
    assign m_ip_ecn       = r_ecn;
    assign m_ip_length    = r_length;
    assign m_ip_ttl       = r_ttl;
    assign m_ip_protocol  = r_protocol;
    assign m_ip_source_ip = r_source_ip;
    assign m_ip_dest_ip   = r_dest_ip;
    assign grant_valid    = r_grant_valid;
    assign grant_index    = r_grant_index;

endmodule
`default_nettype wire
